mat_accum_seq: RTL and testbench
================================

// Module: mat_accum_seq
// PURPOSE
//  Sequencer for the matrix accumulator. Accepts a job config (tile count), then streams partial-product tiles into it.
//  Drives the accumulator's start/operand inputs and presents the finished sum on a valid/ready result port.
//  Sits between the SpMV partial-product stage and the writeback stage; the accumulator is instantiated beside it.
// PARAMETERS
//  DATA_LEN   32                       element width, signed two's complement
//  M          8                        tile rows
//  K          8                        tile columns
//  MAT_SIZE   DATA_LEN*K*M             flat tile width, row-major, element [r][c] at bit r*DATA_LEN*K + c*DATA_LEN
//  MAX_TILES  256                      largest tile count per job
//  CNT_W      $clog2(MAX_TILES+1)      tile-count width
// PORTS
//  i_clk          in   1         clock, all logic on posedge
//  i_rst          in   1         synchronous reset, active-high
//  i_cfg_valid    in   1         job config offered
//  o_cfg_ready    out  1         config accepted when valid&ready; high only in IDLE
//  i_num_tiles    in   CNT_W     tiles in job, legal range 1..MAX_TILES
//  o_cfg_err      out  1         one-cycle pulse: config accepted with illegal count
//  i_tile_valid   in   1         partial tile offered
//  o_tile_ready   out  1         tile accepted when valid&ready; high only in ACCUM
//  i_tile_data    in   MAT_SIZE  partial tile
//  o_accum_start  out  1         to accumulator start: load operand instead of add
//  o_accum_a      out  MAT_SIZE  to accumulator operand
//  i_accum_c      in   MAT_SIZE  from accumulator registered sum
//  o_res_valid    out  1         result held on o_res_data
//  i_res_ready    in   1         result consumed when valid&ready
//  o_res_data     out  MAT_SIZE  result = i_accum_c (combinational pass-through)
//  o_busy         out  1         state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, remaining-count=0, o_cfg_err=0.
//  - Reset values of combinational outputs: o_cfg_ready=1, o_tile_ready=0, o_res_valid=0, o_accum_start=0, o_accum_a=0, o_busy=0.
//  - Reset mid-job: the job is dropped with no result. The accumulator register is not cleared by this block.
//    The next job's first tile overwrites it through o_accum_start.
//  - IDLE: on cfg fire, latch i_num_tiles into remaining, set first-flag, go to ACCUM.
//  - IDLE, i_num_tiles==0 or >MAX_TILES: cfg still accepted; o_cfg_err pulses the next cycle; stay in IDLE.
//  - ACCUM, tile fire:
//    - o_accum_a = i_tile_data (combinational).
//    - o_accum_start = first-flag; clear first-flag.
//    - remaining -= 1.
//  - ACCUM, last tile fire (remaining==1): go to DONE.
//  - ACCUM, no fire: o_accum_a=0, o_accum_start=0, so the accumulator holds its value (adds zero).
//  - DONE: o_res_valid=1. On i_res_ready go to IDLE. Operand stays 0, so the result is stable while stalled.
//  - Latency: o_res_valid rises the cycle after the last tile fire. A back-to-back job of N tiles takes N+1 cycles (IDLE->ACCUM).
//  - Simultaneous events:
//    - cfg is ignored outside IDLE (o_cfg_ready=0).
//    - Result handoff and new cfg never occur in the same cycle; the new cfg is accepted the cycle after DONE->IDLE.
//  - Arithmetic: element-wise DATA_LEN-bit wraparound add, done in the accumulator. This block does no arithmetic on data.
//  - At most one tile accepted per cycle. i_tile_data is sampled only on fire.
// CONFIGURATION
//  - MAT_ACCUM_SEQ_STALL_CNT_EN defined: adds port o_stall_cnt (out, 32).
//    - Counts cycles in ACCUM with i_tile_valid=0, plus cycles in DONE with i_res_ready=0.
//    - Cleared on cfg fire; saturates at 32'hFFFF_FFFF; reset 0.
//  - Not defined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Package mat_accum_pkg:
//    - state enum {IDLE, ACCUM, DONE}.
//    - DATA_LEN/M/K defaults and the MAT_SIZE, CNT_W derivation functions.
//  - Sub-module tile_cnt: loadable down-counter.
//    - Ports: load, value, dec.
//    - Outputs: is_last (==1) and zero.
//  - Accumulator is instantiated at the parent level: its active-low reset pin is driven by ~i_rst.
// TESTING (DATA_LEN=32, M=K=8, bench includes the accumulator)
//  1. cfg num_tiles=3; tiles all-1, all-2, all-4 with valid every cycle
//     -> o_res_valid the cycle after 3rd fire; every element 7.
//  2. Same job with i_tile_valid gaps of 2 cycles between tiles -> result 7 unchanged;
//     with _STALL_CNT_EN, o_stall_cnt=4.
//  3. Hold i_res_ready=0 for 5 cycles -> o_res_data stable at 7, o_tile_ready=0, o_cfg_ready=0;
//     ready -> IDLE next cycle.
//  4. Back-to-back jobs: job A (1 tile, all -5), then job B (2 tiles, all 3)
//     -> results -5 then 6; no carry-over from A.
//  5. cfg num_tiles=0 -> o_cfg_err pulse, o_busy stays 0, no o_accum_start.
//  6. Assert i_rst after 2 of 4 tiles; then job of 1 tile all-9 -> result 9,
//     o_accum_start high on that tile.

Source files
------------

// File: rtl/mat_accum_pkg.sv
// Shared types and sizing helpers for the matrix accumulator sequencer.
package mat_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DATA_LEN_DEF  = 32;
  localparam int M_DEF         = 8;
  localparam int K_DEF         = 8;
  localparam int MAX_TILES_DEF = 256;

  function automatic int mat_size_f(input int data_len, input int m, input int k);
    return data_len * m * k;
  endfunction

  function automatic int cnt_w_f(input int max_tiles);
    return $clog2(max_tiles + 1);
  endfunction

endpackage

// File: rtl/mat_accum_seq_tile_cnt.sv
// Loadable down-counter tracking tiles still owed to the current job.
module tile_cnt #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             is_last,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_last = (cnt == CNT_W'(1));
  assign zero    = (cnt == '0);

endmodule

// File: rtl/mat_accum_seq.sv
// Sequencer feeding partial-product tiles into the matrix accumulator.
// Optional MAT_ACCUM_SEQ_STALL_CNT_EN adds a saturating stall-cycle counter port.
//
// state | meaning
// IDLE  | waiting for a job config
// ACCUM | streaming tiles into the accumulator
// DONE  | holding the finished sum on the result port
module mat_accum_seq
  import mat_accum_pkg::*;
#(
  parameter int  DATA_LEN  = DATA_LEN_DEF,
  parameter int  M         = M_DEF,
  parameter int  K         = K_DEF,
  parameter int  MAX_TILES = MAX_TILES_DEF,
  localparam int MAT_SIZE  = mat_size_f(DATA_LEN, M, K),
  localparam int CNT_W     = cnt_w_f(MAX_TILES)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [CNT_W-1:0]    i_num_tiles,
  output logic                o_cfg_err,
  input  logic                i_tile_valid,
  output logic                o_tile_ready,
  input  logic [MAT_SIZE-1:0] i_tile_data,
  output logic                o_accum_start,
  output logic [MAT_SIZE-1:0] o_accum_a,
  input  logic [MAT_SIZE-1:0] i_accum_c,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic [MAT_SIZE-1:0] o_res_data,
  output logic                o_busy
`ifdef MAT_ACCUM_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]         o_stall_cnt
`endif
);

  state_t state, state_nxt;
  logic   first;
  logic   cfg_fire, cfg_legal, tile_fire;
  logic   cnt_last, cnt_zero;

  assign cfg_fire  = i_cfg_valid && (state == IDLE);
  assign cfg_legal = (i_num_tiles != '0) && (int'(i_num_tiles) <= MAX_TILES);
  assign tile_fire = i_tile_valid && (state == ACCUM) && !cnt_zero;

  tile_cnt #(.CNT_W(CNT_W)) u_tile_cnt (
    .clk     (i_clk),
    .rst     (i_rst),
    .load    (cfg_fire && cfg_legal),
    .value   (i_num_tiles),
    .dec     (tile_fire),
    .is_last (cnt_last),
    .zero    (cnt_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      first     <= 1'b0;
      o_cfg_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_cfg_err <= cfg_fire && !cfg_legal;
      if (cfg_fire && cfg_legal) begin
        first <= 1'b1;
      end else if (tile_fire) begin
        first <= 1'b0;
      end
    end
  end

  // Operand is forced to zero outside a tile fire so the accumulator holds.
  always_comb begin
    state_nxt     = state;
    o_cfg_ready   = 1'b0;
    o_tile_ready  = 1'b0;
    o_res_valid   = 1'b0;
    o_accum_start = 1'b0;
    o_accum_a     = '0;
    case (state)
      IDLE: begin
        o_cfg_ready = 1'b1;
        if (cfg_fire && cfg_legal) state_nxt = ACCUM;
      end
      ACCUM: begin
        o_tile_ready = !cnt_zero;
        if (tile_fire) begin
          o_accum_a     = i_tile_data;
          o_accum_start = first;
          if (cnt_last) state_nxt = DONE;
        end
      end
      DONE: begin
        o_res_valid = 1'b1;
        if (i_res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_res_data = i_accum_c;
  assign o_busy     = (state != IDLE);

`ifdef MAT_ACCUM_SEQ_STALL_CNT_EN
  logic stall_inc;

  assign stall_inc = ((state == ACCUM) && !i_tile_valid) ||
                     ((state == DONE) && !i_res_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
    end else if (cfg_fire) begin
      o_stall_cnt <= '0;
    end else if (stall_inc && (o_stall_cnt != 32'hFFFF_FFFF)) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mat_accum_seq.sv
// Directed self-checking bench for mat_accum_seq with a behavioural accumulator beside it.
module tb_mat_accum_seq;
  import mat_accum_pkg::*;

  localparam int DL       = 32;
  localparam int ELEMS    = 64;
  localparam int MAT_SIZE = DL * ELEMS;
  localparam int CNT_W    = 9;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CNT_W-1:0]    num_tiles;
  logic                cfg_err;
  logic                tile_valid;
  logic                tile_ready;
  logic [MAT_SIZE-1:0] tile_data;
  logic                accum_start;
  logic [MAT_SIZE-1:0] accum_a;
  logic [MAT_SIZE-1:0] accum_c;
  logic                res_valid;
  logic                res_ready;
  logic [MAT_SIZE-1:0] res_data;
  logic                busy;
`ifdef MAT_ACCUM_SEQ_STALL_CNT_EN
  logic [31:0]         stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mat_accum_seq dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cfg_valid   (cfg_valid),
    .o_cfg_ready   (cfg_ready),
    .i_num_tiles   (num_tiles),
    .o_cfg_err     (cfg_err),
    .i_tile_valid  (tile_valid),
    .o_tile_ready  (tile_ready),
    .i_tile_data   (tile_data),
    .o_accum_start (accum_start),
    .o_accum_a     (accum_a),
    .i_accum_c     (accum_c),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready),
    .o_res_data    (res_data),
    .o_busy        (busy)
`ifdef MAT_ACCUM_SEQ_STALL_CNT_EN
    ,
    .o_stall_cnt   (stall_cnt)
`endif
  );

  // Accumulator with active-low reset driven from ~rst: load on start, else element-wise add.
  logic acc_rst_b;
  assign acc_rst_b = ~rst;

  always @(posedge clk) begin
    if (!acc_rst_b) begin
      accum_c <= '0;
    end else begin
      for (int e = 0; e < ELEMS; e++) begin
        if (accum_start) accum_c[e*DL +: DL] <= accum_a[e*DL +: DL];
        else             accum_c[e*DL +: DL] <= accum_c[e*DL +: DL] + accum_a[e*DL +: DL];
      end
    end
  end

  function automatic logic [MAT_SIZE-1:0] fill(input logic [DL-1:0] v);
    logic [MAT_SIZE-1:0] r;
    for (int e = 0; e < ELEMS; e++) r[e*DL +: DL] = v;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_mat(input string tag, input logic [MAT_SIZE-1:0] mat, input logic [DL-1:0] val);
    logic [DL-1:0] obs;
    int idx;
    obs = mat[DL-1:0];
    idx = 0;
    for (int e = 0; e < ELEMS; e++) begin
      if (mat[e*DL +: DL] !== val) begin
        obs = mat[e*DL +: DL];
        idx = e;
        break;
      end
    end
    total++;
    assert (obs === val) else begin
      bad++;
      $error("FAIL %s elem %0d: got %0d want %0d", tag, idx, $signed(obs), $signed(val));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; num_tiles = '0; tile_valid = 1'b0;
    tile_data = '0; res_ready = 1'b0;
    cyc(); cyc(); #1;
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_tile_ready", 64'(tile_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_accum_start", 64'(accum_start), 64'd0);
    chk_mat("rst_accum_a", accum_a, 32'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);

    // Job of 3 tiles, valid every cycle
    cyc(); rst = 1'b0; cfg_valid = 1'b1; num_tiles = 9'd3; #1;
    chk("t1_cfg_ready", 64'(cfg_ready), 64'd1);
    cyc(); cfg_valid = 1'b0; tile_valid = 1'b1; tile_data = fill(32'd1); #1;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_tile_ready", 64'(tile_ready), 64'd1);
    chk("t1_start_first", 64'(accum_start), 64'd1);
    chk_mat("t1_a_first", accum_a, 32'd1);
    cyc(); tile_data = fill(32'd2); #1;
    chk("t1_start_second", 64'(accum_start), 64'd0);
    chk_mat("t1_a_second", accum_a, 32'd2);
    cyc(); tile_data = fill(32'd4); #1;
    chk("t1_no_early_valid", 64'(res_valid), 64'd0);
    cyc(); tile_valid = 1'b0; tile_data = '0; #1;
    chk("t1_res_valid", 64'(res_valid), 64'd1);
    chk_mat("t1_res_data", res_data, 32'd7);
    chk_mat("t1_a_zero_done", accum_a, 32'd0);

    // Result stall: 5 cycles total with res_ready low
    for (int i = 0; i < 4; i++) begin
      cyc(); cfg_valid = 1'b1; num_tiles = 9'd2; #1;
      chk("t3_res_valid", 64'(res_valid), 64'd1);
      chk_mat("t3_res_stable", res_data, 32'd7);
      chk("t3_tile_ready", 64'(tile_ready), 64'd0);
      chk("t3_cfg_ready", 64'(cfg_ready), 64'd0);
    end
    cyc(); cfg_valid = 1'b0; res_ready = 1'b1; #1;
    chk("t3_valid_at_handoff", 64'(res_valid), 64'd1);
    cyc(); res_ready = 1'b0; #1;
    chk("t3_idle_busy", 64'(busy), 64'd0);
    chk("t3_idle_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("t3_idle_res_valid", 64'(res_valid), 64'd0);

    // Same job with 2-cycle gaps between tiles
    cfg_valid = 1'b1; num_tiles = 9'd3; #1;
    cyc(); cfg_valid = 1'b0; tile_valid = 1'b1; tile_data = fill(32'd1); #1;
    chk("t2_start_first", 64'(accum_start), 64'd1);
    cyc(); tile_valid = 1'b0; tile_data = fill(32'd8); #1;
    chk_mat("t2_gap_a_zero", accum_a, 32'd0);
    chk("t2_gap_start", 64'(accum_start), 64'd0);
    cyc(); #1;
    cyc(); tile_valid = 1'b1; tile_data = fill(32'd2); #1;
    chk("t2_start_mid", 64'(accum_start), 64'd0);
    cyc(); tile_valid = 1'b0; tile_data = fill(32'd8); #1;
    cyc(); #1;
    cyc(); tile_valid = 1'b1; tile_data = fill(32'd4); #1;
    cyc(); tile_valid = 1'b0; tile_data = '0; res_ready = 1'b1;
    cfg_valid = 1'b1; num_tiles = 9'd1; #1;
    chk("t2_res_valid", 64'(res_valid), 64'd1);
    chk_mat("t2_res_data", res_data, 32'd7);
    chk("t2_cfg_blocked_in_done", 64'(cfg_ready), 64'd0);
`ifdef MAT_ACCUM_SEQ_STALL_CNT_EN
    chk("t2_stall_cnt", 64'(stall_cnt), 64'd4);
`endif

    // Back-to-back: job A accepted the cycle after DONE->IDLE
    cyc(); res_ready = 1'b0; #1;
    chk("t4_a_cfg_ready", 64'(cfg_ready), 64'd1);
    cyc(); cfg_valid = 1'b0; tile_valid = 1'b1; tile_data = fill(-32'sd5); #1;
    chk("t4_a_start", 64'(accum_start), 64'd1);
    cyc(); tile_valid = 1'b0; tile_data = '0; res_ready = 1'b1; #1;
    chk("t4_a_valid", 64'(res_valid), 64'd1);
    chk_mat("t4_a_res", res_data, -32'sd5);
    cyc(); res_ready = 1'b0; cfg_valid = 1'b1; num_tiles = 9'd2; #1;
    chk("t4_b_cfg_ready", 64'(cfg_ready), 64'd1);
    cyc(); cfg_valid = 1'b0; tile_valid = 1'b1; tile_data = fill(32'd3); #1;
    chk("t4_b_start_first", 64'(accum_start), 64'd1);
    cyc(); #1;
    chk("t4_b_start_second", 64'(accum_start), 64'd0);
    cyc(); tile_valid = 1'b0; tile_data = '0; res_ready = 1'b1; #1;
    chk("t4_b_valid", 64'(res_valid), 64'd1);
    chk_mat("t4_b_res", res_data, 32'd6);
`ifdef MAT_ACCUM_SEQ_STALL_CNT_EN
    chk("t4_b_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    // Illegal counts: 0 and MAX_TILES+1
    cyc(); res_ready = 1'b0; cfg_valid = 1'b1; num_tiles = 9'd0;
    tile_valid = 1'b1; tile_data = fill(32'd9); #1;
    chk("t5_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("t5_no_err_yet", 64'(cfg_err), 64'd0);
    cyc(); cfg_valid = 1'b0; #1;
    chk("t5_err_pulse", 64'(cfg_err), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_no_start", 64'(accum_start), 64'd0);
    chk("t5_tile_ready", 64'(tile_ready), 64'd0);
    cyc(); #1;
    chk("t5_err_cleared", 64'(cfg_err), 64'd0);
    chk("t5_busy_after", 64'(busy), 64'd0);
    cfg_valid = 1'b1; num_tiles = 9'd257; #1;
    cyc(); cfg_valid = 1'b0; #1;
    chk("t5_err_257", 64'(cfg_err), 64'd1);
    chk("t5_busy_257", 64'(busy), 64'd0);
    cfg_valid = 1'b1; num_tiles = 9'd256; #1;
    cyc(); cfg_valid = 1'b0; tile_valid = 1'b0; #1;
    chk("t5_no_err_256", 64'(cfg_err), 64'd0);
    chk("t5_busy_256", 64'(busy), 64'd1);

    // Reset mid-job, then a fresh 1-tile job
    cyc(); rst = 1'b1; #1;
    cyc(); rst = 1'b0; cfg_valid = 1'b1; num_tiles = 9'd4; #1;
    cyc(); cfg_valid = 1'b0; tile_valid = 1'b1; tile_data = fill(32'd1); #1;
    cyc(); #1;
    cyc(); tile_valid = 1'b0; rst = 1'b1; #1;
    cyc(); rst = 1'b0; #1;
    chk("t6_busy_after_rst", 64'(busy), 64'd0);
    chk("t6_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("t6_res_valid", 64'(res_valid), 64'd0);
    chk("t6_cfg_err", 64'(cfg_err), 64'd0);
    cfg_valid = 1'b1; num_tiles = 9'd1; #1;
    cyc(); cfg_valid = 1'b0; tile_valid = 1'b1; tile_data = fill(32'd9); #1;
    chk("t6_start", 64'(accum_start), 64'd1);
    chk_mat("t6_a", accum_a, 32'd9);
    cyc(); tile_valid = 1'b0; tile_data = '0; res_ready = 1'b1; #1;
    chk("t6_res_valid_done", 64'(res_valid), 64'd1);
    chk_mat("t6_res", res_data, 32'd9);
    cyc(); res_ready = 1'b0; #1;
    chk("t6_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
